// File: rtl/button_conditioner.sv
// Front end for the three-floor elevator controller: synchronises and
// debounces six raw push-buttons (three in-car, three hall), converts each
// accepted press into a single-cycle pulse, and keeps a per-floor request
// lamp lit until the car stands at that floor with the door open.
//
// Channel packing used throughout: bits [2:0] are the in-car buttons for
// floors 1..3, and bits [5:3] are the hall buttons for floors 1..3.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int CNT_W           = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:1] rawInButtons,
  input  logic [3:1] rawOutButtons,
  input  logic [3:1] currentFloor,
  input  logic       doorState,
  output logic [3:1] inDoorButtons,
  output logic [3:1] outDoorButtons,
  output logic [3:1] requestLamps,
  output logic       anyPress
);

  // Counter value at which a persistent mismatch is accepted as a new level.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [5:0]       raw;
  logic [5:0]       s1;
  logic [5:0]       s2;
  logic [5:0]       stable;
  logic [5:0]       accept;
  logic [5:0]       pulse;
  logic [CNT_W-1:0] cnt [6];
  logic [2:0]       lamps;
  logic [2:0]       floor_hit;
  logic [2:0]       lamp_set;
  logic [2:0]       lamp_clr;

  assign raw = {rawOutButtons, rawInButtons};

  // Flag channels whose synchronised level has disagreed long enough to be taken.
  always_comb begin
    accept = '0;
    for (int i = 0; i < 6; i++) begin
      accept[i] = (s2[i] != stable[i]) && (cnt[i] == CNT_LAST);
    end
  end

  // Only an exact one-hot floor code can clear a lamp; anything else clears nothing.
  assign floor_hit = {currentFloor == 3'b100, currentFloor == 3'b010, currentFloor == 3'b001};
  assign lamp_clr  = {3{doorState}} & floor_hit;
  assign lamp_set  = pulse[2:0] | pulse[5:3];

  // Two-flop synchroniser for the asynchronous button inputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Debounce: count consecutive mismatching cycles, any matching cycle restarts the count.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      stable <= '0;
      for (int i = 0; i < 6; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (s2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          stable[i] <= s2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Press pulse: high for the one cycle following an accepted 0->1 level; releases give nothing.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pulse <= '0;
    end else begin
      pulse <= accept & s2;
    end
  end

  // Request lamps: a press lights its floor, door open at that floor clears it, clear wins.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      lamps <= '0;
    end else begin
      lamps <= (lamps | lamp_set) & ~lamp_clr;
    end
  end

  assign inDoorButtons  = pulse[2:0];
  assign outDoorButtons = pulse[5:3];
  assign requestLamps   = lamps;
  assign anyPress       = |pulse;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with a short debounce window.
// Expected press pulses are queued with the clock edge on which they must
// appear; a reference model turns them into expected pulse and lamp values
// that are compared against the design on every falling edge.
module tb_button_conditioner;

  localparam int DEB = 4;

  // ---------------------------------------------------------------- clock/reset
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:1] rawInButtons  = '0;
  logic [3:1] rawOutButtons = '0;
  logic [3:1] currentFloor  = 3'b001;
  logic       doorState     = 1'b0;
  logic [3:1] inDoorButtons;
  logic [3:1] outDoorButtons;
  logic [3:1] requestLamps;
  logic       anyPress;

  always #5 CLK = ~CLK;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W(8)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .rawInButtons(rawInButtons),
    .rawOutButtons(rawOutButtons),
    .currentFloor(currentFloor),
    .doorState(doorState),
    .inDoorButtons(inDoorButtons),
    .outDoorButtons(outDoorButtons),
    .requestLamps(requestLamps),
    .anyPress(anyPress)
  );

  // ---------------------------------------------------------------- scoreboard
  // Entry = {edge number on which the pulse appears, {out[3:1], in[3:1]}}.
  logic [37:0] exp_q[$];
  int          cyc       = 0;
  int          pass_cnt  = 0;
  int          total_cnt = 0;
  logic        mon_en    = 1'b0;
  logic [5:0]  exp_pulse = '0;
  logic [2:0]  exp_lamps = '0;
  logic [2:0]  next_lamps;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h at edge %0d", tag, obs, exp, cyc);
  endtask

  // Queue a press whose raw level has just been raised (or whose reset was just released).
  task automatic expect_press(input logic [5:0] pat);
    exp_q.push_back({32'(cyc + DEB + 2), pat});
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // Lamp reference: door open at exactly this one-hot floor clears, else a press sets.
  always_comb begin
    next_lamps = exp_lamps;
    for (int f = 0; f < 3; f++) begin
      logic [3:1] onehot;
      onehot = 3'(1 << f);
      if (doorState && (currentFloor == onehot)) next_lamps[f] = 1'b0;
      else if (exp_pulse[f] || exp_pulse[f+3]) next_lamps[f] = 1'b1;
    end
  end

  // Reference state advanced on each edge, dropped at once by reset.
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      exp_pulse <= '0;
      exp_lamps <= '0;
    end else begin
      exp_lamps <= next_lamps;
      if (exp_q.size() != 0 && exp_q[0][37:6] == 32'(cyc + 1)) begin
        exp_pulse <= exp_q[0][5:0];
        void'(exp_q.pop_front());
      end else begin
        exp_pulse <= '0;
      end
    end
  end

  // Compare outputs mid-cycle against the reference.
  always @(negedge CLK) begin
    if (mon_en) begin
      chk("in_pulse",  32'(inDoorButtons),  32'(exp_pulse[2:0]));
      chk("out_pulse", 32'(outDoorButtons), 32'(exp_pulse[5:3]));
      chk("any_press", 32'(anyPress),       32'(|exp_pulse));
      chk("lamps",     32'(requestLamps),   32'(exp_lamps));
    end
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    #1 RST = 1'b0;
    #1;
    chk("rst_in",    32'(inDoorButtons),  32'd0);
    chk("rst_out",   32'(outDoorButtons), 32'd0);
    chk("rst_any",   32'(anyPress),       32'd0);
    chk("rst_lamps", 32'(requestLamps),   32'd0);
    mon_en = 1'b1;
    step(3);
    RST = 1'b1;
    step(3);

    // Clean press on in-car floor 2, held then released: one pulse, lamp 2 lit.
    rawInButtons[2] = 1'b1;
    expect_press(6'b000_010);
    step(20);
    rawInButtons[2] = 1'b0;
    step(10);

    // Bouncy hall floor 3: one-cycle glitches never qualify.
    rawOutButtons[3] = 1'b1; step(1);
    rawOutButtons[3] = 1'b0; step(1);
    rawOutButtons[3] = 1'b1; step(1);
    rawOutButtons[3] = 1'b0; step(10);

    // Hall floor 1 held long, released with a bounce: one pulse only.
    rawOutButtons[1] = 1'b1;
    expect_press(6'b001_000);
    step(50);
    rawOutButtons[1] = 1'b0; step(1);
    rawOutButtons[1] = 1'b1; step(1);
    rawOutButtons[1] = 1'b0; step(10);

    // Door open at floor 1 clears lamp 1, then light floor 3 to reach 110.
    doorState = 1'b1; step(2);
    doorState = 1'b0;
    rawInButtons[3] = 1'b1;
    expect_press(6'b000_100);
    step(8);
    rawInButtons[3] = 1'b0;
    step(10);
    chk("lamps_110", 32'(requestLamps), 32'b110);

    // Door open at floor 3 clears lamp 3.
    currentFloor = 3'b100; doorState = 1'b1;
    step(3);
    chk("lamps_010", 32'(requestLamps), 32'b010);

    // Door open at floor 2 while floor 2 is pressed: pulse, but lamp stays dark.
    currentFloor = 3'b010;
    rawOutButtons[2] = 1'b1;
    expect_press(6'b010_000);
    step(10);
    rawOutButtons[2] = 1'b0;
    step(10);
    chk("lamps_000", 32'(requestLamps), 32'b000);

    // Simultaneous presses on two channels, then invalid floor codes clear nothing.
    doorState = 1'b0; currentFloor = 3'b001;
    rawInButtons[1]  = 1'b1;
    rawOutButtons[2] = 1'b1;
    expect_press(6'b010_001);
    step(10);
    rawInButtons[1]  = 1'b0;
    rawOutButtons[2] = 1'b0;
    currentFloor = 3'b100;
    step(10);
    currentFloor = 3'b011; doorState = 1'b1;
    step(5);
    currentFloor = 3'b111;
    step(5);
    chk("lamps_invalid_floor", 32'(requestLamps), 32'b011);
    doorState = 1'b0;
    step(2);

    // Reset while in-car floor 1 is two cycles into debouncing, held throughout.
    rawInButtons[1] = 1'b1;
    step(4);
    #2 RST = 1'b0;
    #1;
    chk("midrst_in",    32'(inDoorButtons),  32'd0);
    chk("midrst_out",   32'(outDoorButtons), 32'd0);
    chk("midrst_any",   32'(anyPress),       32'd0);
    chk("midrst_lamps", 32'(requestLamps),   32'd0);
    step(2);
    RST = 1'b1;
    expect_press(6'b000_001);
    step(12);
    rawInButtons[1] = 1'b0;
    step(10);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
